// File: rtl/mem_ctrl_pkg.sv
// Shared types for mem_ctrl: FSM state encoding, access width codes, load helpers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  // Width code 11 falls through to a word access.
  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  width,
                                              input logic        signed_ld);
    case (width)
      WIDTH_BYTE: return signed_ld ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      WIDTH_HALF: return signed_ld ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default:    return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter for instruction fetch and data access; MEM has priority.
// Define MEMCTRL_IF_ABORT_EN to let a data request abandon an in-flight fetch.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_width,
  input  logic        mem_signed,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  state_t      state, state_d;
  logic [2:0]  cnt, cnt_d;
  logic [1:0]  width_q, width_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf, rbuf_d;
  logic [31:0] ram_addr_d, if_data_d, mem_rdata_d;
  logic [7:0]  ram_dout_d;
  logic        ram_wr_d, if_done_d, mem_done_d;
  logic [2:0]  nbytes;
  logic [1:0]  cap_sel;
  logic        idle_ready, take_mem;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  assign nbytes  = width_bytes(width_q);
  assign cap_sel = cnt[1:0] - 2'd1;

  // The done cycle still sees the request that was just served, so it is not sampled.
  assign idle_ready = (state == IDLE) & ~if_done & ~mem_done;

`ifdef MEMCTRL_IF_ABORT_EN
  assign take_mem = mem_req & (idle_ready | (state == IF_RD));
`else
  assign take_mem = mem_req & idle_ready;
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    width_d     = width_q;
    sgn_d       = sgn_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf;
    ram_addr_d  = ram_addr;
    ram_dout_d  = ram_dout;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data;
    mem_rdata_d = mem_rdata;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (idle_ready && if_req) begin
          state_d    = IF_RD;
          width_d    = WIDTH_WORD;
          sgn_d      = 1'b0;
          ram_addr_d = if_addr;
          cnt_d      = '0;
        end
      end
      IF_RD, MEM_RD: begin
        // cnt trails the presented address by one byte: ram_din holds byte cnt-1.
        if (cnt != 3'd0) rbuf_d[{cap_sel, 3'b000} +: 8] = ram_din;
        if (cnt < nbytes - 3'd1) ram_addr_d = ram_addr + 32'd1;
        cnt_d = cnt + 3'd1;
        if (cnt == nbytes) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state == IF_RD) begin
            if_data_d = rbuf_d;
            if_done_d = 1'b1;
          end else begin
            mem_rdata_d = extend_load(rbuf_d, width_q, sgn_q);
            mem_done_d  = 1'b1;
          end
        end
      end
      MEM_WR: begin
        if (cnt < nbytes) begin
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[{cnt[1:0], 3'b000} +: 8];
          ram_addr_d = ram_addr + 32'd1;
          cnt_d      = cnt + 3'd1;
        end else begin
          state_d    = IDLE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Data acceptance overrides whatever the fetch path decided this cycle.
    if (take_mem) begin
      width_d    = mem_width;
      sgn_d      = mem_signed;
      wdata_d    = mem_wdata;
      ram_addr_d = mem_addr;
      if_done_d  = 1'b0;
      if_data_d  = if_data;
      if (mem_we) begin
        state_d    = MEM_WR;
        ram_wr_d   = 1'b1;
        ram_dout_d = mem_wdata[7:0];
        cnt_d      = 3'd1;
      end else begin
        state_d = MEM_RD;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      width_q   <= '0;
      sgn_q     <= 1'b0;
      wdata_q   <= '0;
      rbuf      <= '0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      width_q   <= width_d;
      sgn_q     <= sgn_d;
      wdata_q   <= wdata_d;
      rbuf      <= rbuf_d;
      ram_addr  <= ram_addr_d;
      ram_dout  <= ram_dout_d;
      ram_wr    <= ram_wr_d;
      if_data   <= if_data_d;
      mem_rdata <= mem_rdata_d;
      if_done   <= if_done_d;
      mem_done  <= mem_done_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, vector table, corner sequences, random traffic.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_done, mem_req, mem_we, mem_signed, mem_done;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_addr;
  logic [1:0]  mem_width;
  logic        stall_if, stall_mem, ram_wr;
  logic [7:0]  ram_dout, ram_din;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram     [0:2047];
  logic [7:0]  ref_mem [0:2047];
  int          wr_count = 0;
  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  mem_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_signed(mem_signed), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears in the cycle after the address.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr[10:0]] <= ram_dout;
    ram_din <= ram[ram_addr[10:0]];
  end

  always @(negedge clk) begin
    if (ram_wr) begin
      wr_count++;
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_dout);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned nbytes_of(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input logic sg);
    int unsigned n = nbytes_of(w);
    logic [31:0] v = 32'h0;
    for (int unsigned k = 0; k < n; k++)
      v = v + (32'(ref_mem[(a + k) & 32'h7FF]) << (8 * k));
    if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    for (int unsigned k = 0; k < nbytes_of(w); k++)
      ref_mem[(a + k) & 32'h7FF] = 8'(d >> (8 * k));
  endtask

  task automatic do_mem(input logic we, input logic [1:0] w, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    mem_req = 1'b1; mem_we = we; mem_width = w; mem_signed = sg;
    mem_addr = a; mem_wdata = wd;
    lat = 0; rd = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 0) begin
        check("stall_mem_busy", 32'(stall_mem), 32'd1);
        mem_we = 1'($urandom); mem_width = 2'($urandom); mem_signed = 1'($urandom);
        mem_addr = $urandom; mem_wdata = $urandom;
      end
      if (mem_done) begin
        rd = mem_rdata;
        check("stall_mem_done", 32'(stall_mem), 32'd0);
        break;
      end
    end
    mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_if(input logic [31:0] a, output logic [31:0] d, output int lat);
    if_req = 1'b1; if_addr = a;
    lat = 0; d = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 0) if_addr = $urandom;
      if (if_done) begin
        d = if_data;
        break;
      end
    end
    if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  w;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] rd, got_m, got_i, exp_v;
    int lat, wr0, cyc, mem_at, if_at, stall_bad, restarted;
    logic [7:0] b;
    logic we, sg;
    logic [1:0] w;
    logic [31:0] a, wd;
    int unsigned op;

    reset_n = 1'b0;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0;
    mem_wdata = '0; mem_width = '0; mem_signed = 0;
    for (int i = 0; i < 2048; i++) begin
      b = (i < 256) ? 8'($urandom) : 8'h00;
      if (i == 256) b = 8'h13;
      if (i == 257) b = 8'h05;
      ram[i] <= b;
      ref_mem[i] = b;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_dout", 32'(ram_dout), 32'h0);
    check("rst_ram_wr", 32'(ram_wr), 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_mem_done", 32'(mem_done), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Fetch of 0x100 holding 13 05 00 00
    do_if(32'h100, rd, lat);
    check("fetch_data", rd, 32'h00000513);
    check("fetch_lat", 32'(lat), 32'd6);

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h200, 32'h8001F27F, 32'h00000000, 5};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'h200, 32'h0,        32'h0000007F, 3};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h203, 32'h0,        32'hFFFFFF80, 3};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h203, 32'h0,        32'h00000080, 3};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h200, 32'h0,        32'hFFFFF27F, 4};
    tbl[5]  = '{1'b0, 2'b01, 1'b0, 32'h200, 32'h0,        32'h0000F27F, 4};
    tbl[6]  = '{1'b0, 2'b01, 1'b1, 32'h202, 32'h0,        32'hFFFF8001, 4};
    tbl[7]  = '{1'b0, 2'b10, 1'b1, 32'h200, 32'h0,        32'h8001F27F, 6};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h200, 32'h0,        32'h8001F27F, 6};
    tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h300, 32'h1234BEEF, 32'h8001F27F, 3};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h300, 32'h0,        32'h0000BEEF, 6};
    tbl[11] = '{1'b1, 2'b00, 1'b1, 32'h301, 32'hFFFFFFAA, 32'h0000BEEF, 2};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h300, 32'h0,        32'h0000AAEF, 6};
    tbl[13] = '{1'b1, 2'b11, 1'b0, 32'h304, 32'hCAFEF00D, 32'h0000AAEF, 5};
    tbl[14] = '{1'b0, 2'b01, 1'b1, 32'h306, 32'h0,        32'hFFFFCAFE, 4};
    tbl[15] = '{1'b0, 2'b01, 1'b0, 32'h304, 32'h0,        32'h0000F00D, 4};
    tbl[16] = '{1'b0, 2'b00, 1'b1, 32'h305, 32'h0,        32'hFFFFFFF0, 3};

    for (int i = 0; i < 17; i++) begin
      wr0 = wr_count;
      do_mem(tbl[i].we, tbl[i].w, tbl[i].sg, tbl[i].a, tbl[i].wd, rd, lat);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_wrcnt", i), 32'(wr_count - wr0),
            tbl[i].we ? 32'(nbytes_of(tbl[i].w)) : 32'd0);
      if (tbl[i].we) model_store(tbl[i].a, tbl[i].w, tbl[i].wd);
    end

    // Half store: EF to 0x300 then BE to 0x301
    wr_addr_q.delete(); wr_data_q.delete();
    do_mem(1'b1, 2'b01, 1'b0, 32'h300, 32'h0000BEEF, rd, lat);
    model_store(32'h300, 2'b01, 32'h0000BEEF);
    check("half_st_lat", 32'(lat), 32'd3);
    check("half_st_nwr", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("half_st_a0", wr_addr_q[0], 32'h300);
      check("half_st_d0", 32'(wr_data_q[0]), 32'hEF);
      check("half_st_a1", wr_addr_q[1], 32'h301);
      check("half_st_d1", 32'(wr_data_q[1]), 32'hBE);
    end

    // Simultaneous requests: MEM first, fetch stays stalled until served
    mem_req = 1; mem_we = 0; mem_width = 2'b00; mem_signed = 1; mem_addr = 32'h203;
    if_req = 1; if_addr = 32'h100;
    cyc = 0; mem_at = -1; if_at = -1; stall_bad = 0; got_m = '0; got_i = '0;
    while (if_at < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_done && mem_at < 0) begin mem_at = cyc; got_m = mem_rdata; mem_req = 0; end
      if (if_done) begin if_at = cyc; got_i = if_data; end
      else if (!stall_if) stall_bad++;
    end
    if_req = 0;
    @(posedge clk); #1;
    check("prio_mem_cycle", 32'(mem_at), 32'd3);
    check("prio_order", 32'(if_at > mem_at), 32'd1);
    check("prio_stall_if", 32'(stall_bad), 32'd0);
    check("prio_mem_data", got_m, 32'hFFFFFF80);
    check("prio_if_data", got_i, 32'h00000513);

    // MEM request arriving two cycles into a fetch
    if_req = 1; if_addr = 32'h100;
    repeat (3) begin @(posedge clk); #1; end
    mem_req = 1; mem_we = 0; mem_width = 2'b00; mem_signed = 0; mem_addr = 32'h203;
    @(posedge clk); #1;
`ifdef MEMCTRL_IF_ABORT_EN
    check("mid_fetch_addr", ram_addr, 32'h203);
`else
    check("mid_fetch_addr", ram_addr, 32'h103);
`endif
    cyc = 0; mem_at = -1; if_at = -1; restarted = 0; got_m = '0; got_i = '0;
    while ((mem_at < 0 || if_at < 0) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_done && mem_at < 0) begin mem_at = cyc; got_m = mem_rdata; mem_req = 0; end
      if (if_done && if_at < 0) begin if_at = cyc; got_i = if_data; if_req = 0; end
      if (mem_at >= 0 && if_at < 0 && ram_addr == 32'h100) restarted = 1;
    end
    mem_req = 0; if_req = 0;
    @(posedge clk); #1;
    check("mid_both_done", 32'((mem_at >= 0) && (if_at >= 0)), 32'd1);
    check("mid_mem_data", got_m, 32'h00000080);
    check("mid_if_data", got_i, 32'h00000513);
`ifdef MEMCTRL_IF_ABORT_EN
    check("mid_mem_first", 32'(mem_at < if_at), 32'd1);
    check("mid_restart", 32'(restarted), 32'd1);
`else
    check("mid_mem_first", 32'(mem_at < if_at), 32'd0);
`endif

    // Reset pulsed after two bytes of a word store
    wr0 = wr_count;
    mem_req = 1; mem_we = 1; mem_width = 2'b10; mem_signed = 0;
    mem_addr = 32'h400; mem_wdata = 32'h11223344;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("rstmid_ram_wr", 32'(ram_wr), 32'd0);
    check("rstmid_ram_addr", ram_addr, 32'h0);
    check("rstmid_ram_dout", 32'(ram_dout), 32'h0);
    check("rstmid_if_data", if_data, 32'h0);
    check("rstmid_mem_rdata", mem_rdata, 32'h0);
    check("rstmid_dones", {30'h0, if_done, mem_done}, 32'h0);
    mem_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_nwr", 32'(wr_count - wr0), 32'd2);
    check("rstmid_b0", 32'(ram[1024]), 32'h44);
    check("rstmid_b1", 32'(ram[1025]), 32'h33);
    check("rstmid_b2", 32'(ram[1026]), 32'h00);
    ref_mem[1024] = 8'h44;
    ref_mem[1025] = 8'h33;
    do_mem(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, lat);
    check("rstmid_resume", rd, 32'h00003344);
    check("rstmid_resume_lat", 32'(lat), 32'd6);

    // Random traffic against the byte-array reference
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 248));
      w  = 2'($urandom);
      sg = 1'($urandom);
      wd = $urandom;
      if (op == 0) begin
        wr0 = wr_count;
        we = 1'b1;
        do_mem(we, w, sg, a, wd, rd, lat);
        model_store(a, w, wd);
        check("rnd_st_lat", 32'(lat), 32'(nbytes_of(w) + 1));
        check("rnd_st_nwr", 32'(wr_count - wr0), 32'(nbytes_of(w)));
      end else if (op == 1) begin
        we = 1'b0;
        exp_v = model_load(a, w, sg);
        do_mem(we, w, sg, a, wd, rd, lat);
        check("rnd_ld_data", rd, exp_v);
        check("rnd_ld_lat", 32'(lat), 32'(nbytes_of(w) + 2));
      end else begin
        a = a & 32'hFC;
        exp_v = model_load(a, 2'b10, 1'b0);
        do_if(a, rd, lat);
        check("rnd_if_data", rd, exp_v);
        check("rnd_if_lat", 32'(lat), 32'd6);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
